e_mdu: RTL

- Parametrised multi-cycle multiply/divide unit for the E stage. It is the sequential companion of the E-stage ALU.
- Accepts one operation per start pulse and models a fixed multiply/divide latency. It owns the HI/LO architectural registers.
- Raises busy so the hazard unit stalls D-stage mult/div/mfhi/mflo/mthi/mtlo instructions.
- HI/LO are exported directly; the E-stage result mux selects them for mfhi/mflo.

---
 rtl/e_mdu.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/e_mdu.sv
// E-stage multi-cycle multiply/divide unit owning the HI/LO registers.
// Optional `MDU_CANCEL_EN adds a cancel input that aborts in-flight operations.
module e_mdu #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       MDUOp,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
`ifdef MDU_CANCEL_EN
   ,
   input  logic             cancel
`endif
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

   state_t                 st_r, st_s;
   logic [CW-1:0]          cnt_r, cnt_s;
   logic [WIDTH-1:0]       hi_r, hi_s, lo_r, lo_s;
   logic [WIDTH-1:0]       hin_r, hin_s, lon_r, lon_s;
   logic                   cancel_s;

   logic signed [2*WIDTH-1:0] smul_s;
   logic [2*WIDTH-1:0]        umul_s;
   logic [WIDTH-1:0]          one_s, dvsr_s, uq_s, ur_s;
   logic [WIDTH-1:0]          abs_a_s, abs_b_s, sdvsr_s, sq_mag_s, sr_mag_s, sq_s, sr_s;
   logic                      bzero_s;

`ifdef MDU_CANCEL_EN
   assign cancel_s = cancel;
`else
   assign cancel_s = 1'b0;
`endif

   assign one_s   = {{(WIDTH-1){1'b0}}, 1'b1};
   assign bzero_s = (B == {WIDTH{1'b0}});

   assign smul_s = $signed(A) * $signed(B);
   assign umul_s = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

   // A zero divisor is swapped for one so the dividers never produce X; the result is discarded anyway.
   assign dvsr_s = bzero_s ? one_s : B;
   assign uq_s   = A / dvsr_s;
   assign ur_s   = A % dvsr_s;

   // Signed divide on magnitudes: most-negative / -1 falls out as most-negative with remainder 0.
   assign abs_a_s  = A[WIDTH-1] ? (~A + one_s) : A;
   assign abs_b_s  = B[WIDTH-1] ? (~B + one_s) : B;
   assign sdvsr_s  = bzero_s ? one_s : abs_b_s;
   assign sq_mag_s = abs_a_s / sdvsr_s;
   assign sr_mag_s = abs_a_s % sdvsr_s;
   assign sq_s     = (A[WIDTH-1] ^ B[WIDTH-1]) ? (~sq_mag_s + one_s) : sq_mag_s;
   assign sr_s     = A[WIDTH-1] ? (~sr_mag_s + one_s) : sr_mag_s;

   // Next-state, counter, shadow and architectural register computation.
   always_comb begin
      st_s  = st_r;
      cnt_s = cnt_r;
      hi_s  = hi_r;
      lo_s  = lo_r;
      hin_s = hin_r;
      lon_s = lon_r;
      case (st_r)
         S_IDLE: begin
            if (start && !cancel_s) begin
               case (MDUOp)
                  3'd1: begin
                     hin_s = smul_s[2*WIDTH-1:WIDTH];
                     lon_s = smul_s[WIDTH-1:0];
                     cnt_s = CW'(MULT_CYCLES);
                     st_s  = S_BUSY;
                  end
                  3'd2: begin
                     hin_s = umul_s[2*WIDTH-1:WIDTH];
                     lon_s = umul_s[WIDTH-1:0];
                     cnt_s = CW'(MULT_CYCLES);
                     st_s  = S_BUSY;
                  end
                  3'd3: begin
                     hin_s = bzero_s ? hi_r : sr_s;
                     lon_s = bzero_s ? lo_r : sq_s;
                     cnt_s = CW'(DIV_CYCLES);
                     st_s  = S_BUSY;
                  end
                  3'd4: begin
                     hin_s = bzero_s ? hi_r : ur_s;
                     lon_s = bzero_s ? lo_r : uq_s;
                     cnt_s = CW'(DIV_CYCLES);
                     st_s  = S_BUSY;
                  end
                  3'd5: hi_s = A;
                  3'd6: lo_s = A;
                  default: st_s = S_IDLE;
               endcase
            end else begin
               st_s = S_IDLE;
            end
         end
         S_BUSY: begin
            if (cancel_s) begin
               st_s  = S_IDLE;
               cnt_s = {CW{1'b0}};
            end else if (cnt_r == CW'(1)) begin
               st_s  = S_IDLE;
               cnt_s = {CW{1'b0}};
               hi_s  = hin_r;
               lo_s  = lon_r;
            end else begin
               cnt_s = cnt_r - CW'(1);
            end
         end
         default: begin
            st_s  = S_IDLE;
            cnt_s = {CW{1'b0}};
         end
      endcase
   end

   // State and data registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_r  <= S_IDLE;
         cnt_r <= {CW{1'b0}};
         hi_r  <= {WIDTH{1'b0}};
         lo_r  <= {WIDTH{1'b0}};
         hin_r <= {WIDTH{1'b0}};
         lon_r <= {WIDTH{1'b0}};
      end else begin
         st_r  <= st_s;
         cnt_r <= cnt_s;
         hi_r  <= hi_s;
         lo_r  <= lo_s;
         hin_r <= hin_s;
         lon_r <= lon_s;
      end
   end

   assign busy = (st_r == S_BUSY);
   assign HI   = hi_r;
   assign LO   = lo_r;

endmodule
